qrd_out_deskew: RTL and testbench

- Receiving end of the QRD core's skewed row interface.
- The QRD array emits 4 complex row streams: row k is delayed k-1 cycles relative to row 1, and each row carries 8 elements (4 R columns followed by 4 Q^H columns).
- This block captures one full frame, removes the skew, and presents column-aligned 4-element vectors to downstream logic under a valid/ready handshake.
- It sits between the QRD core outputs and the back-substitution / output formatter.

---
 rtl/qrd_pkg.sv | 26 ++
 rtl/qrd_deskew_row.sv | 43 ++++
 rtl/qrd_out_deskew.sv | 158 +++++++++++++++
 tb/tb_qrd_out_deskew.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qrd_pkg.sv
// rtl/qrd_pkg.sv - shared constants and types for the QRD output deskew slice
package qrd_pkg;

    // Matrix geometry: rows per frame and elements per row (R part + Q^H part)
    localparam int H_SIZE    = 4;
    localparam int N_COLS    = 2 * H_SIZE;
    localparam int SKEW_MAX  = H_SIZE - 1;
    localparam int CAP_LEN   = N_COLS + SKEW_MAX;
    localparam int OUT_WIDTH = 16;

    // Counter widths: cap_cnt must reach CAP_LEN-1, column index must reach N_COLS-1
    localparam int CNT_W = 4;
    localparam int COL_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } qrd_state_t;

    typedef struct packed {
        logic signed [OUT_WIDTH-1:0] r;
        logic signed [OUT_WIDTH-1:0] i;
    } qrd_cplx_t;

endpackage

// File: rtl/qrd_deskew_row.sv
// rtl/qrd_deskew_row.sv - one row buffer that undoes a fixed skew on capture
module qrd_deskew_row
    import qrd_pkg::*;
#(
    parameter int ROW_OFF = 0,
    parameter int W       = OUT_WIDTH
) (
    input  logic                clk,
    input  logic                cap_en,
    input  logic [CNT_W-1:0]    cap_cnt,
    input  logic signed [W-1:0] wr_r,
    input  logic signed [W-1:0] wr_i,
    input  logic [COL_W-1:0]    rd_idx,
    output logic signed [W-1:0] rd_r,
    output logic signed [W-1:0] rd_i
);

    localparam logic [CNT_W:0] OFF_X   = (CNT_W+1)'(ROW_OFF);
    localparam logic [CNT_W:0] NCOLS_X = (CNT_W+1)'(N_COLS);

    logic signed [W-1:0] mem_r [N_COLS];
    logic signed [W-1:0] mem_i [N_COLS];

    // Element index this row is carrying at the current capture cycle; the
    // extra MSB goes high when the row has not started yet (cap_cnt < offset).
    logic [CNT_W:0] diff;
    logic           wr_hit;

    assign diff   = {1'b0, cap_cnt} - OFF_X;
    assign wr_hit = cap_en && !diff[CNT_W] && (diff < NCOLS_X);

    // Store the incoming element at its de-skewed position; storage is not reset
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem_r[diff[COL_W-1:0]] <= wr_r;
            mem_i[diff[COL_W-1:0]] <= wr_i;
        end
    end

    assign rd_r = mem_r[rd_idx];
    assign rd_i = mem_i[rd_idx];

endmodule

// File: rtl/qrd_out_deskew.sv
// rtl/qrd_out_deskew.sv - captures a skewed 4-row QRD frame and drains aligned columns
module qrd_out_deskew
    import qrd_pkg::*;
#(
    parameter int OUT_width = OUT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [OUT_width-1:0] row_in_1_r,
    input  logic signed [OUT_width-1:0] row_in_1_i,
    input  logic signed [OUT_width-1:0] row_in_2_r,
    input  logic signed [OUT_width-1:0] row_in_2_i,
    input  logic signed [OUT_width-1:0] row_in_3_r,
    input  logic signed [OUT_width-1:0] row_in_3_i,
    input  logic signed [OUT_width-1:0] row_in_4_r,
    input  logic signed [OUT_width-1:0] row_in_4_i,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2:0]                  out_col_idx,
    output logic                        out_last,
    output logic signed [OUT_width-1:0] col_out_1_r,
    output logic signed [OUT_width-1:0] col_out_2_r,
    output logic signed [OUT_width-1:0] col_out_3_r,
    output logic signed [OUT_width-1:0] col_out_4_r,
    output logic signed [OUT_width-1:0] col_out_1_i,
    output logic signed [OUT_width-1:0] col_out_2_i,
    output logic signed [OUT_width-1:0] col_out_3_i,
    output logic signed [OUT_width-1:0] col_out_4_i
);

    localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(CAP_LEN - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);

    qrd_state_t       state, state_nxt;
    logic [CNT_W-1:0] cap_cnt, cap_nxt;
    logic [COL_W-1:0] col, col_nxt;

    logic             cap_en;
    logic [CNT_W-1:0] cap_idx;

    logic signed [OUT_width-1:0] wr_r [H_SIZE];
    logic signed [OUT_width-1:0] wr_i [H_SIZE];
    logic signed [OUT_width-1:0] rd_r [H_SIZE];
    logic signed [OUT_width-1:0] rd_i [H_SIZE];

    assign wr_r[0] = row_in_1_r;
    assign wr_i[0] = row_in_1_i;
    assign wr_r[1] = row_in_2_r;
    assign wr_i[1] = row_in_2_i;
    assign wr_r[2] = row_in_3_r;
    assign wr_i[2] = row_in_3_i;
    assign wr_r[3] = row_in_4_r;
    assign wr_i[3] = row_in_4_i;

    // Capture cycle 0 is the in_valid cycle itself, seen while still in IDLE,
    // so row 1 element 0 lands without an extra cycle of latency.
    assign cap_en  = (state == CAPTURE) || ((state == IDLE) && in_valid);
    assign cap_idx = (state == CAPTURE) ? cap_cnt : '0;

    for (genvar k = 0; k < H_SIZE; k++) begin : g_row
        qrd_deskew_row #(
            .ROW_OFF (k),
            .W       (OUT_width)
        ) u_row (
            .clk     (clk),
            .cap_en  (cap_en),
            .cap_cnt (cap_idx),
            .wr_r    (wr_r[k]),
            .wr_i    (wr_i[k]),
            .rd_idx  (col),
            .rd_r    (rd_r[k]),
            .rd_i    (rd_i[k])
        );
    end

    // State and counter registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cap_cnt <= '0;
            col     <= '0;
        end else begin
            state   <= state_nxt;
            cap_cnt <= cap_nxt;
            col     <= col_nxt;
        end
    end

    // Frame sequencing: IDLE -> CAPTURE (11 cycles incl. start) -> DRAIN (8 handshakes)
    always_comb begin
        state_nxt = state;
        cap_nxt   = cap_cnt;
        col_nxt   = col;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = CAPTURE;
                    cap_nxt   = CNT_W'(1);
                    col_nxt   = '0;
                end
            end
            CAPTURE: begin
                if (cap_cnt == CAP_LAST) begin
                    state_nxt = DRAIN;
                    cap_nxt   = '0;
                    col_nxt   = '0;
                end else begin
                    cap_nxt = cap_cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (col == COL_LAST) begin
                        state_nxt = IDLE;
                        col_nxt   = '0;
                    end else begin
                        col_nxt = col + COL_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cap_nxt   = '0;
                col_nxt   = '0;
            end
        endcase
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DRAIN);
    assign out_col_idx = col;
    assign out_last    = (state == DRAIN) && (col == COL_LAST);

    // Column data is forced to zero outside DRAIN so stale buffer contents never show
    always_comb begin
        col_out_1_r = '0;
        col_out_2_r = '0;
        col_out_3_r = '0;
        col_out_4_r = '0;
        col_out_1_i = '0;
        col_out_2_i = '0;
        col_out_3_i = '0;
        col_out_4_i = '0;
        if (state == DRAIN) begin
            col_out_1_r = rd_r[0];
            col_out_2_r = rd_r[1];
            col_out_3_r = rd_r[2];
            col_out_4_r = rd_r[3];
            col_out_1_i = rd_i[0];
            col_out_2_i = rd_i[1];
            col_out_3_i = rd_i[2];
            col_out_4_i = rd_i[3];
        end
    end

endmodule

// File: tb/tb_qrd_out_deskew.sv
// tb/tb_qrd_out_deskew.sv - scoreboard bench for qrd_out_deskew
module tb_qrd_out_deskew;
    import qrd_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic signed [W-1:0] rr [4];
    logic signed [W-1:0] ri [4];

    logic in_ready, out_valid, out_last;
    logic [2:0] out_col_idx;
    logic signed [W-1:0] c1r, c2r, c3r, c4r, c1i, c2i, c3i, c4i;

    qrd_out_deskew #(.OUT_width(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .row_in_1_r  (rr[0]),
        .row_in_1_i  (ri[0]),
        .row_in_2_r  (rr[1]),
        .row_in_2_i  (ri[1]),
        .row_in_3_r  (rr[2]),
        .row_in_3_i  (ri[2]),
        .row_in_4_r  (rr[3]),
        .row_in_4_i  (ri[3]),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_col_idx (out_col_idx),
        .out_last    (out_last),
        .col_out_1_r (c1r),
        .col_out_2_r (c2r),
        .col_out_3_r (c3r),
        .col_out_4_r (c4r),
        .col_out_1_i (c1i),
        .col_out_2_i (c2i),
        .col_out_3_i (c3i),
        .col_out_4_i (c4i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [2:0]   idx;
        logic         last;
    } exp_t;

    exp_t      sb [$];
    qrd_cplx_t fr [4][8];

    int checks   = 0;
    int failures = 0;

    int rmode      = 0;
    int stall_left = 0;
    bit stall_done = 1'b1;

    function automatic logic [127:0] dut_data();
        return {c4i, c4r, c3i, c3r, c2i, c2r, c1i, c1r};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame contents: 0 = test pattern, 1 = negated pattern, 2 = extremes, 3 = random
    task automatic gen_frame(input int mode);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                int v;
                v = 10 * k + j;
                case (mode)
                    0: begin fr[k][j].r = 16'(v);  fr[k][j].i = 16'(-j); end
                    1: begin fr[k][j].r = 16'(-v); fr[k][j].i = 16'(j);  end
                    2: begin
                        fr[k][j].r = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7fff;
                        fr[k][j].i = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7fff;
                    end
                    default: begin
                        fr[k][j].r = 16'($urandom);
                        fr[k][j].i = 16'($urandom);
                    end
                endcase
            end
        end
    endtask

    // Row k carries element c-k at capture cycle c; anything else on the wire is junk
    task automatic drive_slot(input int c);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = c - k;
            if (j >= 0 && j < 8) begin
                rr[k] = fr[k][j].r;
                ri[k] = fr[k][j].i;
            end else begin
                rr[k] = 16'($urandom);
                ri[k] = 16'($urandom);
            end
        end
    endtask

    task automatic push_frame();
        for (int c = 0; c < 8; c++) begin
            exp_t e;
            e.data = '0;
            for (int k = 0; k < 4; k++) begin
                e.data[k*32 +: 16]      = fr[k][c].r;
                e.data[k*32 + 16 +: 16] = fr[k][c].i;
            end
            e.idx  = 3'(c);
            e.last = (c == 7);
            sb.push_back(e);
        end
    endtask

    // Drives one skewed frame; caller is positioned inside the start cycle
    task automatic run_frame(input int spur_cap, input int abort_at);
        bit aborted;
        aborted  = 1'b0;
        in_valid = 1'b1;
        drive_slot(0);
        for (int c = 1; c < 11 && !aborted; c++) begin
            @(posedge clk); #1;
            in_valid = (c == spur_cap);
            drive_slot(c);
            if (c == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n    = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                check("abort_in_ready", 128'(in_ready), 128'(1));
                check("abort_out_valid", 128'(out_valid), 128'(0));
                check("abort_col_idx", 128'(out_col_idx), 128'(0));
                aborted = 1'b1;
            end
        end
        if (!aborted) begin
            push_frame();
            @(negedge clk);
            check("pre_latency_valid", 128'(out_valid), 128'(0));
            @(posedge clk); #1;
            in_valid = 1'b0;
            drive_slot(-8);
        end
    endtask

    // Counts valid cycles until in_ready returns; first cycle must show column 0
    task automatic wait_drain(input int exp_cnt, input bit spur_drain);
        int cnt;
        bit done;
        cnt  = 0;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (n == 0)
                check("first_col", 128'({out_valid, out_col_idx}), 128'({1'b1, 3'd0}));
            if (in_ready) begin
                done = 1'b1;
            end else begin
                if (out_valid) cnt++;
                in_valid = spur_drain && (cnt == 3);
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=busy required=in_ready");
        end
        if (exp_cnt >= 0)
            check("drain_len", 128'(cnt), 128'(exp_cnt));
    endtask

    // Downstream ready: always, random, or a single 3-cycle stall at column 2
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (!stall_done && out_valid && out_col_idx == 3'd2) begin
                        stall_left = 3;
                        stall_done = 1'b1;
                    end
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks hold under back-pressure
    initial begin
        bit   held;
        exp_t prev;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (held) begin
                    check("hold_data", dut_data(), prev.data);
                    check("hold_idx", 128'(out_col_idx), 128'(prev.idx));
                    check("hold_last", 128'(out_last), 128'(prev.last));
                end
                if (out_ready) begin
                    held = 1'b0;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_col actual=idx%0d required=none", out_col_idx);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("col_data", dut_data(), e.data);
                        check("col_idx", 128'(out_col_idx), 128'(e.idx));
                        check("col_last", 128'(out_last), 128'(e.last));
                    end
                end else begin
                    held      = 1'b1;
                    prev.data = dut_data();
                    prev.idx  = out_col_idx;
                    prev.last = out_last;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        drive_slot(-8);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_last", 128'(out_last), 128'(0));
        check("rst_col_idx", 128'(out_col_idx), 128'(0));
        check("rst_col_data", dut_data(), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single frame, ready always high
        gen_frame(0);
        run_frame(-1, -1);
        wait_drain(8, 1'b0);

        // Back-pressure: 3-cycle stall at column 2
        @(posedge clk); #1;
        rmode      = 2;
        stall_done = 1'b0;
        gen_frame(0);
        run_frame(-1, -1);
        wait_drain(11, 1'b0);
        rmode = 0;

        // Spurious in_valid during capture and drain
        @(posedge clk); #1;
        gen_frame(0);
        run_frame(5, -1);
        wait_drain(8, 1'b1);

        // Reset mid-capture, then a clean frame
        @(posedge clk); #1;
        gen_frame(3);
        run_frame(-1, 6);
        @(posedge clk); #1;
        gen_frame(3);
        run_frame(-1, -1);
        wait_drain(8, 1'b0);

        // Back-to-back: second frame starts the first cycle in_ready is high
        @(posedge clk); #1;
        gen_frame(0);
        run_frame(-1, -1);
        wait_drain(8, 1'b0);
        gen_frame(1);
        run_frame(-1, -1);
        wait_drain(8, 1'b0);

        // Extreme values
        @(posedge clk); #1;
        gen_frame(2);
        run_frame(-1, -1);
        wait_drain(8, 1'b0);

        // Random data with random back-pressure and random gaps
        rmode = 1;
        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            gen_frame(3);
            run_frame(-1, -1);
            wait_drain(-1, 1'b0);
        end
        rmode = 0;

        repeat (5) @(negedge clk);
        check("sb_empty", 128'(sb.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
